// File: rtl/prio_encoder_seq.sv
// Registered priority / one-hot encoder with valid-ready handshakes and a
// saturating error counter. MODE 0 demands a strict one-hot input; MODE 1
// picks the highest set bit. Empty (and, in MODE 0, multi-hot) inputs flag err.
module prio_encoder_seq #(
  parameter int unsigned N    = 8,
  parameter int unsigned MODE = 0,
  parameter int unsigned CW   = 8,
  localparam int unsigned W   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          En,
  input  logic [N-1:0]  in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  o,
  output logic          err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] err_cnt,
  input  logic          clr_cnt
);

  logic          seen;
  logic          multi;
  logic [W-1:0]  idx;
  logic [W-1:0]  enc_o;
  logic          enc_err;
  logic          accept;
  logic          drain;

  logic          out_valid_q;
  logic [W-1:0]  o_q;
  logic          err_q;
  logic [CW-1:0] err_cnt_q;

  // Scan upward so idx ends on the highest set bit; idx is always < N.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        idx   = W'(i);
      end
    end
  end

  // Select result and error flag according to the encoding mode.
  always_comb begin
    enc_o   = '0;
    enc_err = 1'b1;
    if (MODE == 0) begin
      enc_err = !seen || multi;
      enc_o   = enc_err ? '0 : idx;
    end else begin
      enc_err = !seen;
      enc_o   = idx;
    end
  end

  // Handshake: gated by reset so nothing is accepted while rst_n is low.
  always_comb begin
    in_ready = rst_n & En & (~out_valid_q | out_ready);
    accept   = in_valid & in_ready;
    drain    = out_valid_q & out_ready;
  end

  // Output register: load on accept, otherwise clear valid on drain and hold data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      o_q         <= '0;
      err_q       <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      o_q         <= enc_o;
      err_q       <= enc_err;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating error counter; a clear wins over a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (clr_cnt) begin
      err_cnt_q <= '0;
    end else if (accept && enc_err && (err_cnt_q != {CW{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CW'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign o         = o_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/prio_encoder_seq.md
PRIO_ENCODER_SEQ -- requirements
Module: prio_encoder_seq

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning input vector width, legal range 2..64.
REQ-002 The block SHALL have parameter MODE, default 0, meaning 0 = strict one-hot, 1 = priority with the highest set bit winning.
REQ-003 The block SHALL have parameter CW, default 8, meaning the error-counter width.
REQ-004 The block SHALL derive localparam W = clog2(N), the output code width.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port En, input, 1 bit: block enable.
REQ-008 Port in, input, N bits: vector to encode.
REQ-009 Port in_valid, input, 1 bit: in is valid.
REQ-010 Port in_ready, output, 1 bit: the block can accept in.
REQ-011 Port o, output, W bits: encoded index.
REQ-012 Port err, output, 1 bit: the result held in o is invalid.
REQ-013 Port out_valid, output, 1 bit: o and err are valid.
REQ-014 Port out_ready, input, 1 bit: downstream accepts o and err.
REQ-015 Port err_cnt, output, CW bits: saturating count of accepted erroneous inputs.
REQ-016 Port clr_cnt, input, 1 bit: synchronous clear of err_cnt.

Function
REQ-017 in_ready SHALL equal En AND (NOT out_valid OR out_ready), combinationally.
REQ-018 An input transfer SHALL occur on a rising edge when in_valid AND in_ready are both 1.
REQ-019 An output transfer SHALL occur on a rising edge when out_valid AND out_ready are both 1.
REQ-020 On an input transfer, o, err and out_valid=1 SHALL be registered, giving a latency of exactly 1 cycle from accept to out_valid.
REQ-021 In MODE 0, when exactly one bit k is set, o SHALL be k and err SHALL be 0.
REQ-022 In MODE 0, when zero bits or two or more bits are set, o SHALL be 0 and err SHALL be 1.
REQ-023 In MODE 1, when at least one bit is set, o SHALL be the index of the highest set bit and err SHALL be 0.
REQ-024 In MODE 1, when in is all zeros, o SHALL be 0 and err SHALL be 1.
REQ-025 With out_valid=1 and out_ready=0, o, err and out_valid SHALL hold unchanged, and in_ready SHALL be 0.
REQ-026 With out_valid=1 and out_ready=1, a new input transfer in the same cycle SHALL replace the output register, with out_valid staying 1 and no bubble, giving full throughput.
REQ-027 An output transfer with no input transfer SHALL clear out_valid, and o and err SHALL hold their last values.
REQ-028 En=0 SHALL block new accepts only; a pending output SHALL still drain via out_ready.
REQ-029 err_cnt SHALL increment by 1 on each input transfer whose computed err is 1, and SHALL saturate at 2^CW-1 without wrapping.
REQ-030 When clr_cnt=1, err_cnt SHALL become 0 on the next edge, taking priority over a simultaneous increment.
REQ-031 When N is not a power of 2, code values >= N SHALL never appear on o.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously force out_valid=0, o=0, err=0 and err_cnt=0, independent of clk.
REQ-033 While rst_n=0, in_ready SHALL be 0.
REQ-034 On the first rising edge after rst_n rises, in_ready SHALL follow REQ-017.
REQ-035 Reset asserted mid-transfer SHALL discard the pending output, and no transfer SHALL complete on that edge.

Verification
REQ-036 Bench SHALL check, with N=8, MODE=0, En=1, out_ready=1: in=8'b00100000 accepted -> next cycle o=3'b101, err=0, out_valid=1.
REQ-037 Bench SHALL check, with N=8, MODE=0: in=8'b00100100 -> o=0, err=1, err_cnt increments 0->1; with MODE=1, the same input -> o=3'b101, err=0, err_cnt unchanged.
REQ-038 Bench SHALL check backpressure: out_ready=0 for 3 cycles after an accept -> o held, in_ready=0; out_ready=1 together with in_valid=1 -> back-to-back results, one per cycle, none lost or duplicated.
REQ-039 Bench SHALL check, with CW=2: 5 erroneous inputs -> err_cnt sequence 1,2,3,3,3; clr_cnt=1 while an erroneous input is accepted -> err_cnt=0.
REQ-040 Bench SHALL check that rst_n pulsed low asynchronously between edges while out_valid=1 -> out_valid, o, err and err_cnt go to 0 immediately, and in_ready=0 until rst_n is released.
REQ-041 Bench SHALL check, with N=5, MODE=1, exhaustive over all 32 inputs: o matches the highest set index, o<5 always, and err=1 only for in=0.
